// File: rtl/input_debouncer_pkg.sv
// Shared defaults and parameter-range rule for the input debouncer and its per-bit cell.
package input_debouncer_pkg;

   localparam int DEFAULT_NR_OF_BITS       = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES  = 4;
   localparam int DEFAULT_COUNTER_WIDTH    = 3;

   // The counter only has to reach DebounceCycles-1, so DebounceCycles may equal 2**CounterWidth.
   function automatic bit debounce_params_ok(input int debounce_cycles, input int counter_width);
      return (debounce_cycles >= 1) && (debounce_cycles <= (1 << counter_width));
   endfunction

endpackage

// File: rtl/input_debouncer_debounce_cell.sv
// Single-bit debouncer: 2-flop synchronizer, tick-gated run counter, registered level and
// one-clock edge strobes.
module debounce_cell
   import input_debouncer_pkg::*;
#(
   parameter int DebounceCycles = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CounterWidth   = DEFAULT_COUNTER_WIDTH
) (
   input  logic clock,
   input  logic reset_n,
   input  logic tick,
   input  logic data_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic match_o
);

   if (!debounce_params_ok(DebounceCycles, CounterWidth)) begin : g_param_check
      $error("debounce_cell: DebounceCycles=%0d out of range for CounterWidth=%0d",
             DebounceCycles, CounterWidth);
   end

   localparam logic [CounterWidth-1:0] LastCount = CounterWidth'(DebounceCycles - 1);

   logic                    s1_q, s2_q;
   logic [CounterWidth-1:0] cnt_q, cnt_d;
   logic                    level_q, level_d;
   logic                    rise_q, rise_d;
   logic                    fall_q, fall_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= data_i;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Agreement clears the count on every clock; only a disagreement waits for tick.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s2_q == level_q) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q == LastCount) begin
            cnt_d   = '0;
            level_d = s2_q;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign match_o = (s2_q == level_q);

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel pad-input debouncer: one debounce_cell per bit plus the global stable flag.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int NrOfBits       = DEFAULT_NR_OF_BITS,
   parameter int DebounceCycles = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CounterWidth   = DEFAULT_COUNTER_WIDTH
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                tick,
   input  logic [NrOfBits-1:0] dataIn,
   output logic [NrOfBits-1:0] dataOut,
   output logic [NrOfBits-1:0] risingEdge,
   output logic [NrOfBits-1:0] fallingEdge,
   output logic                stable
);

   logic [NrOfBits-1:0] match;

   for (genvar i = 0; i < NrOfBits; i++) begin : g_cell
      debounce_cell #(
         .DebounceCycles (DebounceCycles),
         .CounterWidth   (CounterWidth)
      ) u_cell (
         .clock   (clock),
         .reset_n (reset_n),
         .tick    (tick),
         .data_i  (dataIn[i]),
         .level_o (dataOut[i]),
         .rise_o  (risingEdge[i]),
         .fall_o  (fallingEdge[i]),
         .match_o (match[i])
      );
   end

   assign stable = &match;

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized and directed bench for input_debouncer against a tick-counting reference model.
module tb_input_debouncer;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [1:0] data_in;
   logic [1:0] data_out, rising_edge, falling_edge;
   logic       stable;

   logic       data_in1;
   logic       data_out1, rising1, falling1, stable1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference model: s2 is dataIn as it was two edges ago; a channel accepts it once
   // DC ticks have been seen in an unbroken run of disagreement.
   logic [1:0] m_h0, m_h1, m_out, m_rise, m_fall;
   int         m_run [2];
   logic [6:0] exp_q [$];

   always #5 clk = ~clk;

   input_debouncer #(.NrOfBits(2), .DebounceCycles(DC), .CounterWidth(3)) dut (
      .clock       (clk),
      .reset_n     (rst_n),
      .tick        (tick),
      .dataIn      (data_in),
      .dataOut     (data_out),
      .risingEdge  (rising_edge),
      .fallingEdge (falling_edge),
      .stable      (stable)
   );

   input_debouncer #(.NrOfBits(1), .DebounceCycles(1), .CounterWidth(1)) dut1 (
      .clock       (clk),
      .reset_n     (rst_n),
      .tick        (1'b1),
      .dataIn      (data_in1),
      .dataOut     (data_out1),
      .risingEdge  (rising1),
      .fallingEdge (falling1),
      .stable      (stable1)
   );

   function automatic logic [6:0] exp_vec();
      return {m_out, m_rise, m_fall, (m_h1 == m_out)};
   endfunction

   function automatic logic [6:0] act_vec();
      return {data_out, rising_edge, falling_edge, stable};
   endfunction

   task automatic model_clear();
      m_h0 = '0; m_h1 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      m_run[0] = 0; m_run[1] = 0;
   endtask

   task automatic step(input logic [1:0] d, input logic t);
      data_in = d;
      tick    = t;
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < 2; i++) begin
            if (m_h1[i] == m_out[i]) begin
               m_run[i] = 0;
            end else if (t) begin
               m_run[i]++;
               if (m_run[i] == DC) begin
                  m_out[i] = m_h1[i];
                  m_run[i] = 0;
                  if (m_h1[i]) m_rise[i] = 1'b1;
                  else         m_fall[i] = 1'b1;
               end
            end
         end
         m_h1 = m_h0;
         m_h0 = d;
      end
      #1;
   endtask

   task automatic test_reset();
      int found = 0;
      logic [6:0] act;
      total_cnt++;
      if (act_vec() !== 7'b00_00_00_1) $display("FAIL reset_initial got=%b exp=%b", act_vec(), 7'b0000001);
      else pass_cnt++;
      step(2'b00, 1'b1);
      step(2'b00, 1'b1);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) step(2'b11, 1'b1);
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      total_cnt++;
      if (act_vec() !== 7'b00_00_00_1) $display("FAIL reset_mid_count got=%b exp=%b", act_vec(), 7'b0000001);
      else pass_cnt++;
      @(negedge clk);
      step(2'b11, 1'b1);
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step(2'b11, 1'b1);
         act = act_vec();
         total_cnt++;
         if (act !== exp_vec()) $display("FAIL reset_restart_model step=%0d got=%b exp=%b", k, act, exp_vec());
         else pass_cnt++;
         if (k == 2) begin
            total_cnt++;
            if (stable !== 1'b0) $display("FAIL reset_stable_refill got=%b exp=0", stable);
            else pass_cnt++;
         end
         if (found == 0 && data_out == 2'b11) found = k;
      end
      total_cnt++;
      if (found != 6) $display("FAIL reset_restart_latency got=%0d exp=6", found);
      else pass_cnt++;
   endtask

   task automatic test_falling_simultaneous();
      int found = 0, fall_steps = 0;
      for (int k = 1; k <= 10; k++) begin
         step(2'b00, 1'b1);
         total_cnt++;
         if (act_vec() !== exp_vec()) $display("FAIL falling_model step=%0d got=%b exp=%b", k, act_vec(), exp_vec());
         else pass_cnt++;
         total_cnt++;
         if (rising_edge !== 2'b00) $display("FAIL falling_no_rise step=%0d got=%b exp=00", k, rising_edge);
         else pass_cnt++;
         if (falling_edge != 2'b00) fall_steps++;
         if (falling_edge == 2'b11 && found == 0) found = k;
      end
      total_cnt++;
      if (found != 6 || fall_steps != 1)
         $display("FAIL falling_both_once got=step%0d/%0d exp=step6/1", found, fall_steps);
      else pass_cnt++;
   endtask

   task automatic test_clean_step();
      int found = 0;
      for (int k = 1; k <= 10; k++) begin
         step(2'b01, 1'b1);
         total_cnt++;
         if (act_vec() !== exp_vec()) $display("FAIL clean_model step=%0d got=%b exp=%b", k, act_vec(), exp_vec());
         else pass_cnt++;
         if (found == 0 && data_out == 2'b01) begin
            found = k;
            total_cnt++;
            if (rising_edge !== 2'b01 || stable !== 1'b1)
               $display("FAIL clean_strobe got=rise%b/stable%b exp=rise01/stable1", rising_edge, stable);
            else pass_cnt++;
         end else if (found != 0 && k == found + 1) begin
            total_cnt++;
            if (rising_edge !== 2'b00) $display("FAIL clean_strobe_width got=%b exp=00", rising_edge);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (found != 6) $display("FAIL clean_latency got=%0d exp=6", found);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      for (int k = 0; k < 8; k++) step(2'b00, 1'b1);
      for (int k = 0; k < 12; k++) begin
         step((k < 3) ? 2'b01 : 2'b00, 1'b1);
         total_cnt++;
         if ({data_out, rising_edge, falling_edge} !== 6'b0 || act_vec() !== exp_vec())
            $display("FAIL glitch step=%0d got=%b exp=%b", k, act_vec(), exp_vec());
         else pass_cnt++;
      end
      for (int k = 0; k < 5; k++) step(2'b01, 1'b1);
      total_cnt++;
      if (data_out !== 2'b00) $display("FAIL glitch_full_restart got=%b exp=00", data_out);
      else pass_cnt++;
      for (int k = 0; k < 5; k++) step(2'b00, 1'b1);
   endtask

   task automatic test_tick_gating();
      int ticks = 0, ticks_at_rise = -1;
      logic t;
      for (int c = 0; c < 48; c++) begin
         t = (c % 8 == 7);
         step(2'b10, t);
         if (t && c >= 2) ticks++;
         total_cnt++;
         if (act_vec() !== exp_vec()) $display("FAIL tick_model cyc=%0d got=%b exp=%b", c, act_vec(), exp_vec());
         else pass_cnt++;
         if (ticks_at_rise < 0 && data_out[1]) ticks_at_rise = ticks;
      end
      total_cnt++;
      if (ticks_at_rise != 4) $display("FAIL tick_gating got=%0d exp=4", ticks_at_rise);
      else pass_cnt++;
   endtask

   task automatic test_min_depth();
      logic [2:0] got;
      data_in1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(data_in, 1'b1);
         got = {data_out1, rising1, falling1};
         total_cnt++;
         if (got !== ((k == 2) ? 3'b110 : (k == 3) ? 3'b100 : 3'b000))
            $display("FAIL min_depth_rise edge=%0d got=%b", k, got);
         else pass_cnt++;
      end
      data_in1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(data_in, 1'b1);
         got = {data_out1, rising1, falling1};
         total_cnt++;
         if (got !== ((k == 2) ? 3'b001 : (k < 2) ? 3'b100 : 3'b000))
            $display("FAIL min_depth_fall edge=%0d got=%b", k, got);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [1:0] d = data_in;
      logic [6:0] exp, act;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 5) == 0) d = 2'($urandom_range(0, 3));
         step(d, $urandom_range(0, 3) != 0);
         exp_q.push_back(exp_vec());
         act = act_vec();
         exp = exp_q.pop_front();
         total_cnt++;
         if (act !== exp || (rising_edge & falling_edge) != 2'b00)
            $display("FAIL random cyc=%0d got=%b exp=%b", c, act, exp);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      tick     = 1'b1;
      data_in  = 2'b00;
      data_in1 = 1'b0;
      model_clear();
      #1;
      test_reset();
      test_falling_simultaneous();
      test_clean_step();
      test_glitch();
      test_tick_gating();
      test_min_depth();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
